// File: rtl/rpm_dac_writer.sv
// rpm_dac_writer
//   Converts the measured speed into a 16-bit DAC code once per update tick
//   and shifts it out to the analog-output DAC over a 24-bit SPI frame
//   (8'h00 control byte, then the code, MSB first).
//
//   code = dac_org +/- dac_width_10V * min(rpm_val, rpm_range) / rpm_range,
//   saturated to 0..65535, with calibration overrides (calib_10V wins over
//   calib_org). The division is a 32-cycle restoring divider.
//
// Ports
//   CLK_60         60 MHz system clock
//   RST            asynchronous active-high reset
//   dac_org        zero-speed DAC code
//   dac_width_10V  DAC code span for full scale
//   rpm_range      full-scale speed
//   calib_org      force output to dac_org
//   calib_10V      force output to dac_org + dac_width_10V
//   rpm_val        measured speed magnitude
//   rpm_dir        0 = forward (add), 1 = reverse (subtract)
//   SCLK, SYNC_N, DIN  DAC serial interface (SYNC_N active low)
//   dac_code       last code transmitted
//   busy           high from the cycle after latch to the end of the gap
//   frame_done     one-cycle pulse in the last gap cycle
//   overrun        sticky: an update tick arrived while busy
module rpm_dac_writer #(
  parameter int unsigned TICK_DIV  = 60000,
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic        CLK_60,
  input  logic        RST,
  input  logic [15:0] dac_org,
  input  logic [15:0] dac_width_10V,
  input  logic [15:0] rpm_range,
  input  logic        calib_org,
  input  logic        calib_10V,
  input  logic [15:0] rpm_val,
  input  logic        rpm_dir,
  output logic        SCLK,
  output logic        SYNC_N,
  output logic        DIN,
  output logic [15:0] dac_code,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = (2 * SCLK_HALF > 1) ? $clog2(2 * SCLK_HALF) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PH_LOW    = PW'(SCLK_HALF);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * SCLK_HALF - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, SAT, TX, GAP} state_t;

  state_t state, state_d;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  // values latched at the start of a frame
  logic [15:0] org_l, width_l, range_l, rpm_l;
  logic        dir_l, c10_l, corg_l;

  // divider: prod holds the dividend and shifts quotient bits in from the LSB
  logic [31:0] prod;
  logic [15:0] rem;
  logic [4:0]  div_cnt;
  logic [16:0] rem_sh;
  logic [15:0] rem_sub;
  logic        rem_ge;

  // saturation stage
  logic [15:0] quot;
  logic [16:0] sum17, diff17, cal17;
  logic [15:0] speed_code, cal_code, code_sat;
  logic [15:0] code_r;

  // transmit counters
  logic [PW-1:0] ph_cnt, ph_d;
  logic [4:0]    bit_cnt, bit_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [23:0]   frame_word;

  logic sclk_d, sync_n_d, din_d, busy_d, frame_done_d;

  assign tick = (tick_cnt == TICK_LAST);

  // ---------------------------------------------------------------- datapath
  assign rem_sh  = {rem, prod[31]};
  assign rem_ge  = (rem_sh >= {1'b0, range_l});
  // remainder after a successful subtract is below the divisor, so the low
  // 16 bits of the modular difference are exact
  assign rem_sub = rem_sh[15:0] - range_l;

  assign quot   = (range_l == '0) ? '0 : prod[15:0];
  assign sum17  = {1'b0, org_l} + {1'b0, quot};
  assign diff17 = {1'b0, org_l} - {1'b0, quot};
  assign cal17  = {1'b0, org_l} + {1'b0, width_l};

  always_comb begin
    speed_code = '0;
    if (dir_l) begin
      speed_code = diff17[16] ? '0 : diff17[15:0];
    end else begin
      speed_code = sum17[16] ? '1 : sum17[15:0];
    end
    cal_code = cal17[16] ? '1 : cal17[15:0];
    code_sat = speed_code;
    if (c10_l) begin
      code_sat = cal_code;
    end else if (corg_l) begin
      code_sat = org_l;
    end
  end

  // the first transmitted bit is the control-byte MSB (constant 0), so the
  // SAT->TX cycle may read frame_word before code_r has been loaded
  assign frame_word = {8'h00, code_r};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK_60 or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    ph_d    = '0;
    bit_d   = '0;
    gap_d   = '0;
    case (state)
      IDLE: if (tick) state_d = MUL;
      MUL:  state_d = DIV;
      DIV:  if (div_cnt == 5'd31) state_d = SAT;
      SAT:  state_d = TX;
      TX: begin
        if (ph_cnt == PH_LAST) begin
          ph_d  = '0;
          bit_d = bit_cnt + 5'd1;
          if (bit_cnt == 5'd23) state_d = GAP;
        end else begin
          ph_d  = ph_cnt + PW'(1);
          bit_d = bit_cnt;
        end
      end
      GAP: begin
        gap_d = gap_cnt + GW'(1);
        if (gap_cnt == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != TX) begin
      ph_d  = '0;
      bit_d = '0;
    end
    if (state_d != GAP) begin
      gap_d = '0;
    end

    // outputs are registered from the next-state view to keep pins glitch-free
    sync_n_d     = (state_d != TX);
    sclk_d       = !((state_d == TX) && (ph_d >= PH_LOW));
    din_d        = (state_d == TX) ? frame_word[5'd23 - bit_d] : 1'b0;
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == GAP) && (gap_d == GAP_LAST);
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge CLK_60 or posedge RST) begin
    if (RST) begin
      tick_cnt   <= '0;
      org_l      <= '0;
      width_l    <= '0;
      range_l    <= '0;
      rpm_l      <= '0;
      dir_l      <= 1'b0;
      c10_l      <= 1'b0;
      corg_l     <= 1'b0;
      prod       <= '0;
      rem        <= '0;
      div_cnt    <= '0;
      code_r     <= 16'h8000;
      ph_cnt     <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      SCLK       <= 1'b1;
      SYNC_N     <= 1'b1;
      DIN        <= 1'b0;
      dac_code   <= 16'h8000;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            org_l   <= dac_org;
            width_l <= dac_width_10V;
            range_l <= rpm_range;
            rpm_l   <= (rpm_val > rpm_range) ? rpm_range : rpm_val;
            dir_l   <= rpm_dir;
            c10_l   <= calib_10V;
            corg_l  <= calib_org;
          end
        end
        MUL: begin
          prod    <= {16'b0, width_l} * {16'b0, rpm_l};
          rem     <= '0;
          div_cnt <= '0;
        end
        DIV: begin
          rem     <= rem_ge ? rem_sub : rem_sh[15:0];
          prod    <= {prod[30:0], rem_ge};
          div_cnt <= div_cnt + 5'd1;
        end
        SAT: begin
          code_r <= code_sat;
        end
        TX: begin
          if (state_d == GAP) begin
            dac_code <= code_r;
          end
        end
        default: ;
      endcase

      ph_cnt     <= ph_d;
      bit_cnt    <= bit_d;
      gap_cnt    <= gap_d;
      SCLK       <= sclk_d;
      SYNC_N     <= sync_n_d;
      DIN        <= din_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_rpm_dac_writer.sv
// Testbench for rpm_dac_writer: randomized and directed frames, expected codes
// queued from an arithmetic reference model, SPI frames decoded by a monitor.
module tb_rpm_dac_writer;

  localparam int unsigned TICK_DIV  = 100;
  localparam int unsigned SCLK_HALF = 2;
  localparam int unsigned GAP_CYC   = 4;
  // the latch cycle has counter value TICK_DIV-1; SYNC_N falls 35 cycles later
  localparam int FIRST_FALL = TICK_DIV - 1 + 35;
  // 134-cycle frames overrun every other tick, so frames repeat every 2 ticks
  localparam int FRAME_PER = 2 * TICK_DIV;

  logic        CLK_60 = 1'b0;
  logic        RST;
  logic [15:0] dac_org, dac_width_10V, rpm_range, rpm_val;
  logic        calib_org, calib_10V, rpm_dir;
  logic        SCLK, SYNC_N, DIN, busy, frame_done, overrun;
  logic [15:0] dac_code;

  rpm_dac_writer #(.TICK_DIV(TICK_DIV), .SCLK_HALF(SCLK_HALF), .GAP_CYC(GAP_CYC)) dut (
    .CLK_60(CLK_60), .RST(RST),
    .dac_org(dac_org), .dac_width_10V(dac_width_10V), .rpm_range(rpm_range),
    .calib_org(calib_org), .calib_10V(calib_10V),
    .rpm_val(rpm_val), .rpm_dir(rpm_dir),
    .SCLK(SCLK), .SYNC_N(SYNC_N), .DIN(DIN), .dac_code(dac_code),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 CLK_60 = ~CLK_60;

  int cyc;
  always @(posedge CLK_60 or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int checks = 0;
  int passes = 0;
  int exp_q[$];
  int next_lc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ref_code(input int org, input int w, input int rng,
                                  input int val, input bit dir, input bit c10,
                                  input bit corg);
    longint q, r;
    int v;
    if (c10) return (org + w > 65535) ? 65535 : org + w;
    if (corg) return org;
    v = (val > rng) ? rng : val;
    q = (rng == 0) ? 0 : (longint'(w) * v) / rng;
    r = dir ? org - q : org + q;
    if (r < 0) r = 0;
    if (r > 65535) r = 65535;
    return int'(r);
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK_60);
  endtask

  task automatic run_frame(input int org, input int w, input int rng, input int val,
                           input bit dir, input bit c10, input bit corg);
    int lc;
    lc = next_lc;
    wait_cyc(lc - 40);
    dac_org = org[15:0]; dac_width_10V = w[15:0]; rpm_range = rng[15:0];
    rpm_val = val[15:0]; rpm_dir = dir; calib_10V = c10; calib_org = corg;
    exp_q.push_back(ref_code(org, w, rng, val, dir, c10, corg));
    wait_cyc(lc + 5);
    // only the latched values may influence this frame
    dac_org = 16'($urandom); dac_width_10V = 16'($urandom); rpm_range = 16'($urandom);
    rpm_val = 16'($urandom); rpm_dir = 1'($urandom);
    calib_10V = 1'($urandom); calib_org = 1'($urandom);
    next_lc = lc + FRAME_PER;
  endtask

  task automatic random_frame();
    int rng;
    rng = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 65535));
    run_frame(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), rng,
              int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
  endtask

  // ------------------------------------------------------------ monitor
  logic        prev_sclk = 1'b1, prev_sync = 1'b1, prev_din = 1'b0, prev_busy = 1'b0;
  logic [23:0] sh;
  int          nbits;
  bit          in_frame = 0, din_bad = 0, first_fall = 1;
  int          rise_cyc = -100, fd_cyc = -100, e;

  always @(negedge CLK_60) begin
    if (RST) begin
      in_frame = 0; first_fall = 1; rise_cyc = -100; fd_cyc = -100;
      prev_sclk = 1'b1; prev_sync = 1'b1; prev_din = 1'b0; prev_busy = 1'b0;
    end else begin
      if (prev_sync && !SYNC_N) begin
        in_frame = 1; nbits = 0; sh = '0; din_bad = 0;
        chk("sclk_high_at_sync_fall", SCLK, 1);
        if (first_fall) chk("first_sync_fall_cycle", cyc, FIRST_FALL);
        else            chk("sync_fall_cycle_mod", (cyc - FIRST_FALL) % FRAME_PER, 0);
        first_fall = 0;
      end
      if (!SYNC_N && !prev_sync && (DIN != prev_din) && !(!prev_sclk && SCLK)) din_bad = 1;
      if (!SYNC_N && prev_sclk && !SCLK) begin
        sh = {sh[22:0], DIN};
        nbits++;
      end
      if (!prev_sync && SYNC_N && in_frame) begin
        in_frame = 0;
        rise_cyc = cyc;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("spi_bit_count", nbits, 24);
        chk("din_stable_when_sclk_low", din_bad, 0);
        chk("spi_word", sh, e);
        chk("dac_code_after_frame", dac_code, e);
        chk("sclk_high_after_frame", SCLK, 1);
      end
      if (frame_done) begin
        chk("frame_done_timing", cyc - rise_cyc, GAP_CYC - 1);
        fd_cyc = cyc;
      end
      if (prev_busy && !busy) chk("busy_drop_after_done", cyc - fd_cyc, 1);
      prev_sclk = SCLK; prev_sync = SYNC_N; prev_din = DIN; prev_busy = busy;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    int lc;
    RST = 1'b1;
    dac_org = 16'd0; dac_width_10V = 16'd0; rpm_range = 16'd0; rpm_val = 16'd0;
    rpm_dir = 1'b0; calib_org = 1'b0; calib_10V = 1'b0;
    repeat (3) @(negedge CLK_60);
    chk("reset_sync_n", SYNC_N, 1);
    chk("reset_sclk", SCLK, 1);
    chk("reset_din", DIN, 0);
    chk("reset_dac_code", dac_code, 16'h8000);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_overrun", overrun, 0);
    RST = 1'b0;
    next_lc = TICK_DIV - 1;

    lc = next_lc;
    run_frame(32768, 27692, 400, 200, 0, 0, 0);           // 46614
    chk("busy_after_latch", busy, 1);
    wait_cyc(lc + 51);
    chk("overrun_before_busy_tick", overrun, 0);
    wait_cyc(lc + TICK_DIV + 2);
    chk("overrun_after_busy_tick", overrun, 1);

    run_frame(32768, 27692, 400, 500, 1, 0, 0);           // 5076
    run_frame(1000,  27692, 400, 500, 1, 0, 0);           // 0
    run_frame(40000, 30000, 400, 200, 0, 1, 0);           // 65535
    run_frame(40000, 30000, 400, 200, 0, 0, 1);           // 40000
    run_frame(40000, 30000, 400, 200, 1, 1, 1);           // 65535
    run_frame(12345, 30000, 0,   123, 0, 0, 0);           // 12345
    chk("overrun_sticky", overrun, 1);
    for (int i = 0; i < 6; i++) random_frame();

    // reset during bit 10 of the transmission
    lc = next_lc;
    random_frame();
    wait_cyc(lc + 35 + 10 * 2 * SCLK_HALF + 1);
    chk("sync_low_before_abort", SYNC_N, 0);
    #2 RST = 1'b1;
    #1;
    chk("abort_sync_n_async", SYNC_N, 1);
    chk("abort_sclk_async", SCLK, 1);
    chk("abort_dac_code", dac_code, 16'h8000);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (3) @(negedge CLK_60);
    RST = 1'b0;
    next_lc = TICK_DIV - 1;
    chk("overrun_cleared_by_reset", overrun, 0);

    lc = next_lc;
    run_frame(32768, 27692, 400, 200, 0, 0, 0);           // 46614
    wait_cyc(lc + 35 + 24 * 2 * SCLK_HALF - 1);
    chk("dac_code_held_until_frame_end", dac_code, 16'h8000);
    random_frame();
    lc = next_lc;
    random_frame();
    wait_cyc(lc + 150);
    chk("all_frames_seen", exp_q.size(), 0);
    chk("overrun_final", overrun, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rpm_dac_writer.md
Name: rpm_dac_writer

Overview:
- Consumer of the switch-state block's settings: `dac_org`, `dac_width_10V`, `rpm_range`, `calib_org`, `calib_10V`.
- At a fixed 1 kHz rate it converts the measured speed into a 16-bit DAC code, then shifts the code out over SPI to the analog-output DAC.
- The conversion uses a 32-cycle sequential divider.
- Sits between the speed-measurement block and the external DAC pins.

Parameters:
- `TICK_DIV`, 60000: CLK_60 cycles per update (1 kHz).
- `SCLK_HALF`, 2: CLK_60 cycles per SCLK half-period (15 MHz SCLK).
- `GAP_CYC`, 4: minimum CLK_60 cycles SYNC_N stays high between frames.

Ports:
- `CLK_60` in 1: 60 MHz system clock.
- `RST` in 1: asynchronous, active-high reset.
- `dac_org` in 16: zero-speed DAC code.
- `dac_width_10V` in 16: DAC code span for full scale (10 V).
- `rpm_range` in 16: full-scale speed.
- `calib_org` in 1: force output to `dac_org`.
- `calib_10V` in 1: force output to `dac_org + dac_width_10V`.
- `rpm_val` in 16: measured speed magnitude.
- `rpm_dir` in 1: 0 = forward (add), 1 = reverse (subtract).
- `SCLK` out 1: DAC serial clock.
- `SYNC_N` out 1: DAC frame select, active low.
- `DIN` out 1: DAC serial data.
- `dac_code` out 16: last code transmitted.
- `busy` out 1: high from latch until the end of GAP.
- `frame_done` out 1: one-cycle pulse at the end of GAP.
- `overrun` out 1: sticky; a tick arrived while `busy`.

Behaviour:
- Reset values: `SCLK`=1, `SYNC_N`=1, `DIN`=0, `dac_code`=16'h8000, `busy`=0, `frame_done`=0, `overrun`=0, tick counter=0, state=IDLE.
- Reset mid-frame aborts immediately; `SYNC_N` returns high asynchronously.
- Tick counter: counts 0..TICK_DIV-1 and wraps. `tick`=1 in the cycle the counter equals TICK_DIV-1.
- IDLE:
  - On `tick`, latch all inputs and go to MUL; `busy`=1 from the next cycle.
  - Latched `rpm_val` is clamped to the latched `rpm_range`.
- Tick while not IDLE: ignored, sets `overrun`. `overrun` clears only on RST.
- MUL (1 cycle): `prod[31:0]` = `dac_width_10V` × clamped rpm.
- DIV (32 cycles): restoring divide, one quotient bit per cycle, MSB first, `prod / rpm_range`.
  - Quotient is ≤ `dac_width_10V`, so 16 bits suffice.
  - `rpm_range`==0: quotient forced to 0; DIV still takes 32 cycles.
- SAT (1 cycle):
  - Compute in 17 bits: `rpm_dir`=0 → `dac_org` + q; `rpm_dir`=1 → `dac_org` − q.
  - Clamp to 0..65535.
  - `calib_10V`=1: code = sat(`dac_org` + `dac_width_10V`), overriding the speed result.
  - Else `calib_org`=1: code = `dac_org`.
  - Both flags high: `calib_10V` wins.
- TX:
  - `SYNC_N` falls on the first TX cycle, exactly 35 CLK_60 cycles after the latch cycle.
  - Frame is 24 bits, MSB first: 8'h00 control byte, then code[15:0].
  - `DIN` changes on the SCLK rising edge and is stable across the falling edge, where the DAC samples.
  - The first bit is driven when `SYNC_N` falls, with `SCLK` high.
  - Each bit = 2×SCLK_HALF cycles: SCLK_HALF cycles high, then SCLK_HALF cycles low.
  - After the 24th low phase, `SCLK`=1 and `SYNC_N`=1; `dac_code` updates to the sent code in that cycle.
- GAP:
  - `SYNC_N` high for GAP_CYC cycles.
  - `frame_done` pulses in the last GAP cycle; `busy` drops the next cycle.
- Total busy time with defaults: 1+32+1+96+4 = 134 cycles, well under TICK_DIV.
- Inputs may change at any time; only latched values are used within a frame.

Test Plan:
- Reset, no input activity → `SYNC_N`=1, `SCLK`=1, `dac_code`=16'h8000; first `SYNC_N` fall at cycle 60000+35 after reset release.
- `dac_org`=32768, `dac_width_10V`=27692, `rpm_range`=400, `rpm_val`=200, `rpm_dir`=0 → 24 captured bits = 24'h00_B616 (32768+13846); `dac_code`=46614; `frame_done` pulses once.
- Same settings with `rpm_dir`=1, `rpm_val`=500 (clamped to 400) → code 5076. Then `dac_org`=1000 → 0 (low saturation).
- `calib_10V`=1 with `dac_org`=40000, `dac_width_10V`=30000 → code 65535. `calib_org`=1 alone → code 40000. Both high → 65535.
- `rpm_range`=0, `rpm_val`=123 → code = `dac_org`. Force a tick while `busy` (TICK_DIV=100 in bench) → `overrun`=1 and stays 1; the frame in progress is unaffected.
- Assert RST during bit 10 of TX → `SYNC_N`, `SCLK` high immediately. After release, the next frame is complete and correct; `dac_code` is 16'h8000 until that frame ends.
